// File: rtl/i_decode.sv
// i_decode -- instruction-decode stage of a five-stage MIPS pipeline.
//
// Reads the 32x32 register file for the IF/ID instruction, decodes the
// control bundle, sign-extends the immediate and registers it all into the
// ID/EX pipeline register. It also takes the MEM/WB write-back port and
// raises a combinational load-use stall that injects one bubble.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   IF_ID_instr/npc     instruction and PC+4 from IF/ID
//   MEM_WB_RegWrite     write-back enable
//   MEM_WB_WriteReg     write-back destination register
//   WB_data             write-back data
//   ID_EX_wb            {RegWrite, MemtoReg}
//   ID_EX_m             {Branch, MemRead, MemWrite}
//   ID_EX_ex            {RegDst, ALUOp[1:0], ALUSrc}
//   ID_EX_npc           registered PC+4
//   ID_EX_readdat1/2    register values at rs / rt
//   ID_EX_sign_ext      sign-extended immediate
//   ID_EX_instr_2016    rt field
//   ID_EX_instr_1511    rd field
//   id_stall            load-use hazard flag, tells IF to hold PC and IF/ID
module i_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteReg,
    input  logic [31:0] WB_data,
    output logic [1:0]  ID_EX_wb,
    output logic [2:0]  ID_EX_m,
    output logic [3:0]  ID_EX_ex,
    output logic [31:0] ID_EX_npc,
    output logic [31:0] ID_EX_readdat1,
    output logic [31:0] ID_EX_readdat2,
    output logic [31:0] ID_EX_sign_ext,
    output logic [4:0]  ID_EX_instr_2016,
    output logic [4:0]  ID_EX_instr_1511,
    output logic        id_stall
);

    logic [31:0] regs [0:31];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wb_en;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] sign_ext;
    logic [1:0]  ctl_wb;
    logic [2:0]  ctl_m;
    logic [3:0]  ctl_ex;

    assign opcode   = IF_ID_instr[31:26];
    assign rs       = IF_ID_instr[25:21];
    assign rt       = IF_ID_instr[20:16];
    assign sign_ext = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

    // Writes to $0 are dropped, so entry 0 stays at its reset value of zero.
    assign wb_en = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en) begin
            regs[MEM_WB_WriteReg] <= WB_data;
        end
    end

    // Write-through bypass: a write landing this cycle is visible to the
    // reader in the same cycle, since both commit on the same edge.
    always_comb begin
        rd_data1 = regs[rs];
        rd_data2 = regs[rt];
        if (rs == 5'd0) begin
            rd_data1 = 32'd0;
        end else if (wb_en && (MEM_WB_WriteReg == rs)) begin
            rd_data1 = WB_data;
        end
        if (rt == 5'd0) begin
            rd_data2 = 32'd0;
        end else if (wb_en && (MEM_WB_WriteReg == rt)) begin
            rd_data2 = WB_data;
        end
    end

    // Control decode; unknown opcodes become a NOP.
    always_comb begin
        ctl_ex = 4'b0000;
        ctl_m  = 3'b000;
        ctl_wb = 2'b00;
        case (opcode)
            6'h00: begin
                ctl_ex = 4'b1100;
                ctl_m  = 3'b000;
                ctl_wb = 2'b10;
            end
            6'h23: begin
                ctl_ex = 4'b0001;
                ctl_m  = 3'b010;
                ctl_wb = 2'b11;
            end
            6'h2B: begin
                ctl_ex = 4'b0001;
                ctl_m  = 3'b001;
                ctl_wb = 2'b00;
            end
            6'h04: begin
                ctl_ex = 4'b0010;
                ctl_m  = 3'b100;
                ctl_wb = 2'b00;
            end
            default: begin
                ctl_ex = 4'b0000;
                ctl_m  = 3'b000;
                ctl_wb = 2'b00;
            end
        endcase
    end

    // Load-use hazard: the load now in EX targets a register this
    // instruction reads. Loads into $0 never create a dependency.
    assign id_stall = ID_EX_m[1]
                   && (ID_EX_instr_2016 != 5'd0)
                   && ((ID_EX_instr_2016 == rs) || (ID_EX_instr_2016 == rt));

    // On a stall, only the control fields are zeroed to form the bubble.
    // The bubble clears MemRead, so a stall can last at most one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_wb         <= 2'b00;
            ID_EX_m          <= 3'b000;
            ID_EX_ex         <= 4'b0000;
            ID_EX_npc        <= 32'd0;
            ID_EX_readdat1   <= 32'd0;
            ID_EX_readdat2   <= 32'd0;
            ID_EX_sign_ext   <= 32'd0;
            ID_EX_instr_2016 <= 5'd0;
            ID_EX_instr_1511 <= 5'd0;
        end else begin
            if (id_stall) begin
                ID_EX_wb <= 2'b00;
                ID_EX_m  <= 3'b000;
                ID_EX_ex <= 4'b0000;
            end else begin
                ID_EX_wb <= ctl_wb;
                ID_EX_m  <= ctl_m;
                ID_EX_ex <= ctl_ex;
            end
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= rd_data1;
            ID_EX_readdat2   <= rd_data2;
            ID_EX_sign_ext   <= sign_ext;
            ID_EX_instr_2016 <= IF_ID_instr[20:16];
            ID_EX_instr_1511 <= IF_ID_instr[15:11];
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode -- directed self-checking bench for i_decode.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or a few ns after it for the asynchronous-reset checks).
module tb_i_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] WB_data;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;
    logic        id_stall;

    int total;
    int bad;

    i_decode dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .WB_data          (WB_data),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_readdat1   (ID_EX_readdat1),
        .ID_EX_readdat2   (ID_EX_readdat2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_instr_2016 (ID_EX_instr_2016),
        .ID_EX_instr_1511 (ID_EX_instr_1511),
        .id_stall         (id_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] npc,
                                 input logic we, input logic [4:0] wreg,
                                 input logic [31:0] wdata);
        IF_ID_instr     = instr;
        IF_ID_npc       = npc;
        MEM_WB_RegWrite = we;
        MEM_WB_WriteReg = wreg;
        WB_data         = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkControl(input string tag, input logic [3:0] ex,
                                input logic [2:0] m, input logic [1:0] wb);
        checkOutput({tag, "_ex"}, 32'(ID_EX_ex), 32'(ex));
        checkOutput({tag, "_m"},  32'(ID_EX_m),  32'(m));
        checkOutput({tag, "_wb"}, 32'(ID_EX_wb), 32'(wb));
    endtask

    task automatic checkAllZero(input string tag);
        checkControl(tag, 4'b0000, 3'b000, 2'b00);
        checkOutput({tag, "_npc"},   ID_EX_npc, 32'd0);
        checkOutput({tag, "_rd1"},   ID_EX_readdat1, 32'd0);
        checkOutput({tag, "_rd2"},   ID_EX_readdat2, 32'd0);
        checkOutput({tag, "_sext"},  ID_EX_sign_ext, 32'd0);
        checkOutput({tag, "_rt"},    32'(ID_EX_instr_2016), 32'd0);
        checkOutput({tag, "_rd"},    32'(ID_EX_instr_1511), 32'd0);
        checkOutput({tag, "_stall"}, 32'(id_stall), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        checkAllZero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Write $1=5, $2=7, then decode add $3,$1,$2
        applyStimulus(32'h0, 32'h4, 1'b1, 5'd1, 32'd5);
        tick();
        applyStimulus(32'h0, 32'h4, 1'b1, 5'd2, 32'd7);
        tick();
        applyStimulus(32'h00221820, 32'd8, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("add_rd1", ID_EX_readdat1, 32'd5);
        checkOutput("add_rd2", ID_EX_readdat2, 32'd7);
        checkControl("add", 4'b1100, 3'b000, 2'b10);
        checkOutput("add_rd", 32'(ID_EX_instr_1511), 32'd3);
        checkOutput("add_npc", ID_EX_npc, 32'd8);

        // Same-cycle write of $1 is bypassed to the reader
        applyStimulus(32'h00221820, 32'd12, 1'b1, 5'd1, 32'h1234);
        tick();
        checkOutput("byp_rd1", ID_EX_readdat1, 32'h1234);
        checkOutput("byp_rd2", ID_EX_readdat2, 32'd7);

        // $0 is never written and never bypassed
        applyStimulus(32'h00001020, 32'd16, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        checkOutput("r0_byp_rd1", ID_EX_readdat1, 32'd0);
        checkOutput("r0_byp_rd2", ID_EX_readdat2, 32'd0);
        applyStimulus(32'h00001020, 32'd20, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("r0_rd1", ID_EX_readdat1, 32'd0);
        checkOutput("r0_rd2", ID_EX_readdat2, 32'd0);

        // beq with negative immediate
        applyStimulus(32'h1022FFFF, 32'd24, 1'b0, 5'd0, 32'h0);
        tick();
        checkControl("beq", 4'b0010, 3'b100, 2'b00);
        checkOutput("beq_sext", ID_EX_sign_ext, 32'hFFFF_FFFF);

        // sw
        applyStimulus(32'hAC410008, 32'd28, 1'b0, 5'd0, 32'h0);
        tick();
        checkControl("sw", 4'b0001, 3'b001, 2'b00);
        checkOutput("sw_sext", ID_EX_sign_ext, 32'h8);

        // Unknown opcode 0x3F
        applyStimulus(32'hFC000000, 32'd32, 1'b0, 5'd0, 32'h0);
        tick();
        checkControl("nop", 4'b0000, 3'b000, 2'b00);

        // lw decode; next instruction reads no matching register
        applyStimulus(32'h8C410004, 32'd36, 1'b0, 5'd0, 32'h0);
        tick();
        checkControl("lw", 4'b0001, 3'b010, 2'b11);
        checkOutput("lw_sext", ID_EX_sign_ext, 32'h4);
        checkOutput("lw_rt", 32'(ID_EX_instr_2016), 32'd1);
        checkOutput("lw_rd1", ID_EX_readdat1, 32'd7);
        applyStimulus(32'hFC000000, 32'd40, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("lw_nodep_stall", 32'(id_stall), 32'd0);
        tick();

        // Load-use: lw $1 then add reading $1; write-back of $4 in the stall cycle
        applyStimulus(32'h8C410000, 32'd44, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(32'h00221820, 32'd48, 1'b1, 5'd4, 32'h99);
        #1;
        checkOutput("lu_stall", 32'(id_stall), 32'd1);
        @(negedge clk);
        checkControl("bubble", 4'b0000, 3'b000, 2'b00);
        applyStimulus(32'h00221820, 32'd48, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("post_bubble_stall", 32'(id_stall), 32'd0);
        @(negedge clk);
        checkControl("reissue", 4'b1100, 3'b000, 2'b10);
        checkOutput("reissue_npc", ID_EX_npc, 32'd48);
        applyStimulus(32'h00802020, 32'd52, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("wb_during_stall", ID_EX_readdat1, 32'h99);

        // lw into $0 never stalls a reader of $0
        applyStimulus(32'h8C400000, 32'd56, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("lw0_memread", 32'(ID_EX_m), 32'b010);
        applyStimulus(32'h00001020, 32'd60, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("lw0_stall", 32'(id_stall), 32'd0);
        tick();

        // Asynchronous reset in the middle of a stall
        applyStimulus(32'h8C410000, 32'd64, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(32'h00221820, 32'd68, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("pre_rst_stall", 32'(id_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        @(posedge clk);
        #1;
        checkOutput("rst_hold_stall", 32'(id_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h00221820, 32'd72, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("rst_r1", ID_EX_readdat1, 32'd0);
        checkOutput("rst_r2", ID_EX_readdat2, 32'd0);
        checkControl("rst_first", 4'b1100, 3'b000, 2'b10);
        checkOutput("rst_first_npc", ID_EX_npc, 32'd72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
